acq_sequencer: RTL and testbench
================================

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 SHALL have parameter ADC_W, default 14, meaning ADC sample width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 9, meaning capture buffer address width (512 entries).
REQ-003 SHALL have port clk_clk, in, 1: sole clock.
REQ-004 SHALL have port reset_reset_n, in, 1: asynchronous active-low reset.
REQ-005 SHALL have port adc_valid, in, 1: adc_data qualifier.
REQ-006 SHALL have port adc_data, in, ADC_W: unsigned sample.
REQ-007 SHALL have port cfg_threshold, in, ADC_W: event threshold.
REQ-008 SHALL have port cfg_min_len, in, 9: minimum accepted event length.
REQ-009 SHALL have port arm, in, 1: level from the HPS PIO; 0 = disable.
REQ-010 SHALL have port ack, in, 1: level from the HPS PIO; rising edge releases a completed event.
REQ-011 SHALL have port rd_ptr, in, 9: HPS read pointer (to data_out_readpointer).
REQ-012 SHALL have port rd_data, out, 32: buffer read word (to data_in_readbuffer).
REQ-013 SHALL have port trigger, out, 1: event ready (to data_in_trigger).
REQ-014 SHALL have port samples, out, 9: event length (to data_in_samples).
REQ-015 SHALL have port cumsum, out, 28: event sample sum (to data_in_cumsum).
REQ-016 SHALL have port exptime, out, 32: event start timestamp (to data_in_exptime).
REQ-017 SHALL have port led, out, 8: status (to led_external_connection).

Function
REQ-018 SHALL implement FSM states IDLE, ARMED, CAPTURE, DONE.
REQ-019 SHALL force IDLE from any state, next cycle, when arm=0; IDLE->ARMED when arm=1.
REQ-020 SHALL keep a free-running 32-bit cycle counter, cleared when arm=0, wrapping 0xFFFFFFFF->0.
REQ-021 ARMED->CAPTURE SHALL occur on adc_valid=1 and adc_data > cfg_threshold (strict), latching the counter into the timestamp register and writing the sample at address 0.
REQ-022 In CAPTURE, each adc_valid sample above threshold SHALL be written at the next address, and added to a 28-bit zero-extended accumulator.
REQ-023 CAPTURE SHALL end on the first adc_valid sample <= threshold (not stored) or after the 511th stored sample, whichever comes first.
REQ-024 At end, length < cfg_min_len SHALL discard the event (outputs unchanged, go to ARMED); otherwise samples/cumsum/exptime SHALL update and state SHALL go to DONE.
REQ-025 trigger SHALL be 1 only in DONE; samples/cumsum/exptime SHALL stay stable while trigger=1.
REQ-026 DONE->ARMED SHALL occur one cycle after a detected rising edge of ack; ack edges outside DONE SHALL be ignored.
REQ-027 Rising-edge detection of ack SHALL use a registered previous value; ack held high SHALL produce one edge.
REQ-028 rd_data SHALL be {7'b0, rd_ptr_q, 2'b0, mem[rd_ptr_q]} with rd_ptr_q = rd_ptr registered; latency 1 cycle from rd_ptr to rd_data.
REQ-029 Reads SHALL be served in every state; a read of an address written the same cycle SHALL return old data.
REQ-030 led[0]=ARMED, led[1]=CAPTURE, led[2]=trigger, led[7:3]=accepted-event count mod 32.
REQ-031 adc_valid=0 cycles in CAPTURE SHALL neither store nor terminate.

Reset
REQ-032 On reset_reset_n=0, SHALL asynchronously enter IDLE; trigger, samples, cumsum, exptime, led, rd_data, counters, ack history all 0.
REQ-033 Buffer contents SHALL NOT require reset; reset mid-CAPTURE SHALL discard the event.

Structure
REQ-034 FSM state enum, DEPTH_LOG2, and rd_data field offsets SHALL live in package acq_pkg.
REQ-035 The buffer SHALL be sub-module acq_sample_ram: simple dual-port, 512 x ADC_W, synchronous read, one write port.

Verification
REQ-036 arm=1, threshold=100, min_len=3, samples 50,150,200,250,90 -> trigger=1, samples=3, cumsum=600, exptime=cycle of 150.
REQ-037 Same setup, samples 150,160,90 -> event discarded, trigger=0, state ARMED, led[7:3] unchanged.
REQ-038 600 consecutive samples of 1000 -> samples=511, cumsum=511000, DONE; further samples ignored.
REQ-039 In DONE, rd_ptr=5 -> rd_data next cycle = {7'b0, 9'd5, 2'b0, stored sample 5}; ack 0->1 -> trigger=0 and ARMED next cycle.
REQ-040 arm dropped mid-CAPTURE -> IDLE next cycle, trigger=0; reset_reset_n pulse mid-CAPTURE -> all outputs 0 immediately.

Source files
------------

// File: rtl/acq_pkg.sv
// acq_pkg: shared types and constants for the acquisition sequencer.
//   DEPTH_LOG2  capture buffer address width (512 entries)
//   ACC_W       event sum accumulator width
//   RD_*_LSB    bit offsets of the fields packed into rd_data
//   acq_state_e sequencer FSM states
package acq_pkg;
    localparam int DEPTH_LOG2  = 9;
    localparam int ACC_W       = 28;
    localparam int RD_DATA_LSB = 0;
    localparam int RD_PTR_LSB  = 16;
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} acq_state_e;
endpackage

// File: rtl/acq_sample_ram.sv
// acq_sample_ram: simple dual-port capture buffer, one write port, registered read.
//   clk_i      clock
//   wr_en_i    write strobe, wr_addr_i / wr_data_i write address and sample
//   rd_addr_i  read address, rd_data_o read sample one cycle later
// Read-first: a read of the address being written returns the previous contents.
// No reset on purpose so the array maps onto block RAM.
module acq_sample_ram import acq_pkg::*; #(
    parameter int W  = 14,
    parameter int AW = DEPTH_LOG2
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);
    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
        rd_data_o <= mem[rd_addr_i];
    end
endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: threshold-triggered ADC event capture with HPS handshake.
//   clk_clk, reset_reset_n   clock, asynchronous active-low reset
//   adc_valid, adc_data      sample stream
//   cfg_threshold            samples strictly above this belong to an event
//   cfg_min_len              shorter events are discarded
//   arm, ack                 HPS levels: enable, and release of a completed event (rising edge)
//   rd_ptr, rd_data          buffer read port, rd_data = {ptr, sample} one cycle after rd_ptr
//   trigger                  event ready; samples/cumsum/exptime describe it
//   led                      {event count mod 32, trigger, capture, armed}
module acq_sequencer import acq_pkg::*; #(
    parameter int ADC_W      = 14,
    parameter int DEPTH_LOG2 = acq_pkg::DEPTH_LOG2
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  adc_valid,
    input  logic [ADC_W-1:0]      adc_data,
    input  logic [ADC_W-1:0]      cfg_threshold,
    input  logic [DEPTH_LOG2-1:0] cfg_min_len,
    input  logic                  arm,
    input  logic                  ack,
    input  logic [DEPTH_LOG2-1:0] rd_ptr,
    output logic [31:0]           rd_data,
    output logic                  trigger,
    output logic [DEPTH_LOG2-1:0] samples,
    output logic [ACC_W-1:0]      cumsum,
    output logic [31:0]           exptime,
    output logic [7:0]            led
);
    localparam int AW = DEPTH_LOG2;
    // Largest event the buffer can hold; reaching it ends the capture.
    localparam logic [AW-1:0] LEN_MAX = '1;

    acq_state_e       state_q, state_d;
    logic [31:0]      cnt_q, ts_q, ts_d;
    logic [AW-1:0]    len_q, len_d, len_inc, fin_len, wr_addr, rd_ptr_q;
    logic [ACC_W-1:0] acc_q, acc_d, acc_add, fin_acc;
    logic [4:0]       evt_q, evt_d;
    logic [ADC_W-1:0] ram_rd;
    logic             ack_q, rd_vld_q, above, fin, wr_en, accept;

    assign above   = adc_valid && (adc_data > cfg_threshold);
    assign len_inc = len_q + 1'b1;
    assign acc_add = acc_q + ACC_W'(adc_data);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        acc_d   = acc_q;
        ts_d    = ts_q;
        wr_en   = 1'b0;
        wr_addr = len_q;
        fin     = 1'b0;
        fin_len = len_q;
        fin_acc = acc_q;
        case (state_q)
            S_IDLE: state_d = S_ARMED;
            S_ARMED: if (above) begin
                state_d = S_CAPTURE;
                wr_en   = 1'b1;
                wr_addr = '0;
                len_d   = AW'(1);
                acc_d   = ACC_W'(adc_data);
                ts_d    = cnt_q;
            end
            S_CAPTURE: if (above) begin
                wr_en   = 1'b1;
                len_d   = len_inc;
                acc_d   = acc_add;
                fin     = (len_inc == LEN_MAX);
                fin_len = len_inc;
                fin_acc = acc_add;
            end else if (adc_valid) begin
                fin = 1'b1;
            end
            S_DONE: if (ack && !ack_q) state_d = S_ARMED;
            default: state_d = S_IDLE;
        endcase
        if (fin) state_d = (fin_len < cfg_min_len) ? S_ARMED : S_DONE;
        // Disarm overrides everything, including a capture ending this cycle.
        if (!arm) begin
            state_d = S_IDLE;
            wr_en   = 1'b0;
            fin     = 1'b0;
        end
    end

    assign accept = fin && (state_d == S_DONE);
    assign evt_d  = evt_q + {4'b0, accept};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ts_q     <= '0;
            len_q    <= '0;
            acc_q    <= '0;
            evt_q    <= '0;
            ack_q    <= 1'b0;
            trigger  <= 1'b0;
            samples  <= '0;
            cumsum   <= '0;
            exptime  <= '0;
            led      <= '0;
            rd_ptr_q <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= arm ? cnt_q + 32'd1 : '0;
            ts_q     <= ts_d;
            len_q    <= len_d;
            acc_q    <= acc_d;
            evt_q    <= evt_d;
            ack_q    <= ack;
            trigger  <= (state_d == S_DONE);
            led      <= {evt_d, state_d == S_DONE, state_d == S_CAPTURE, state_d == S_ARMED};
            rd_ptr_q <= rd_ptr;
            rd_vld_q <= 1'b1;
            if (accept) begin
                samples <= fin_len;
                cumsum  <= fin_acc;
                exptime <= ts_q;
            end
        end
    end

    acq_sample_ram #(.W(ADC_W), .AW(AW)) u_ram (
        .clk_i     (clk_clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (adc_data),
        .rd_addr_i (rd_ptr),
        .rd_data_o (ram_rd)
    );

    // The RAM output register has no reset; rd_vld_q holds rd_data at zero until
    // the first read after reset has completed.
    always_comb begin
        rd_data = '0;
        if (rd_vld_q) begin
            rd_data[RD_PTR_LSB +: AW]     = rd_ptr_q;
            rd_data[RD_DATA_LSB +: ADC_W] = ram_rd;
        end
    end
endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: scoreboard bench for acq_sequencer with a sequence-level reference model.
module tb_acq_sequencer;
    logic        clk_clk = 1'b0;
    logic        reset_reset_n, adc_valid, arm, ack, trigger;
    logic [13:0] adc_data, cfg_threshold;
    logic [8:0]  cfg_min_len, rd_ptr, samples;
    logic [31:0] rd_data, exptime;
    logic [27:0] cumsum;
    logic [7:0]  led;

    acq_sequencer #(.ADC_W(14), .DEPTH_LOG2(9)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .cfg_threshold (cfg_threshold),
        .cfg_min_len   (cfg_min_len),
        .arm           (arm),
        .ack           (ack),
        .rd_ptr        (rd_ptr),
        .rd_data       (rd_data),
        .trigger       (trigger),
        .samples       (samples),
        .cumsum        (cumsum),
        .exptime       (exptime),
        .led           (led)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct { bit v; int d; } beat_t;
    typedef struct { int len; longint sum; longint ts; int cnt; } evt_t;
    typedef struct { longint tick; longint val; } rd_t;

    beat_t  beats[$];
    evt_t   exp_q[$];
    rd_t    rd_q[$];
    int     model_mem[512];
    int     thr, min_len, evt_cnt, last_len;
    longint tick_no, arm_tick;
    int     checks, errors;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        tick_no++;
        #1;
    endtask

    task automatic set_cfg(input int t, input int m);
        thr = t;
        min_len = m;
        cfg_threshold = 14'(t);
        cfg_min_len = 9'(m);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm_tick = tick_no;
        check("armed_led0", led[0], 1);
    endtask

    // Scan the beat list: an event starts at a valid sample above threshold and
    // collects further valid above-threshold samples until a valid sample at or
    // below threshold or 511 stored. Short events are dropped and scanning goes
    // on; the first accepted event is the only one (the sequencer then waits for ack).
    task automatic predict(output bit hit);
        int i;
        i = 0;
        hit = 1'b0;
        while (i < beats.size() && !hit) begin
            if (beats[i].v && beats[i].d > thr) begin
                int start, n;
                longint s;
                int tmp[$];
                start = i;
                n = 0;
                s = 0;
                while (i < beats.size() && n < 511) begin
                    if (beats[i].v) begin
                        if (beats[i].d <= thr) break;
                        tmp.push_back(beats[i].d);
                        n++;
                        s += beats[i].d;
                    end
                    i++;
                end
                if (n >= min_len) begin
                    evt_t e;
                    hit = 1'b1;
                    evt_cnt++;
                    e.len = n;
                    e.sum = s;
                    e.ts = (tick_no + 1 + start) - arm_tick;
                    e.cnt = evt_cnt;
                    exp_q.push_back(e);
                    last_len = n;
                    foreach (tmp[k]) model_mem[k] = tmp[k];
                end
            end else begin
                i++;
            end
        end
    endtask

    task automatic do_read(input int a);
        rd_t r;
        rd_ptr = 9'(a);
        r.tick = tick_no + 1;
        r.val = (longint'(a) << 16) | longint'(model_mem[a]);
        rd_q.push_back(r);
        tick();
    endtask

    task automatic run_burst(input bit ack_held);
        bit hit;
        beat_t t;
        t.v = 1'b1;
        t.d = 0;
        beats.push_back(t);
        if (ack_held) begin
            ack = 1'b1;
            tick();
        end
        predict(hit);
        foreach (beats[k]) begin
            adc_valid = beats[k].v;
            adc_data = 14'(beats[k].d);
            tick();
        end
        adc_valid = 1'b0;
        tick();
        if (hit) begin
            for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
            check("event_seen", exp_q.size(), 0);
            check("done_trigger", trigger, 1);
            if (last_len > 5) do_read(5);
            do_read(0);
            do_read(last_len - 1);
            do_read($urandom_range(0, last_len - 1));
            tick();
            tick();
            check("reads_done", rd_q.size(), 0);
            if (ack_held) begin
                repeat (3) tick();
                check("ackheld_trigger", trigger, 1);
                ack = 1'b0;
                tick();
            end
            ack = 1'b1;
            tick();
            check("ack_trigger", trigger, 0);
            check("ack_armed", led[2:0], 1);
            ack = 1'b0;
            tick();
        end else begin
            check("discard_trigger", trigger, 0);
            check("discard_led_cnt", led[7:3], evt_cnt % 32);
            check("discard_armed", led[2:0], 1);
        end
        beats.delete();
    endtask

    task automatic add_beat(input bit v, input int d);
        beat_t b;
        b.v = v;
        b.d = d;
        beats.push_back(b);
    endtask

    // Monitor: compares each new event against the scoreboard and every read
    // result in the cycle it is due.
    initial begin
        logic trig_prev;
        evt_t e;
        rd_t r;
        trig_prev = 1'b0;
        forever begin
            @(negedge clk_clk);
            if (trigger === 1'b1 && !trig_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_trigger: got samples %0d expected no event", samples);
                end else begin
                    e = exp_q.pop_front();
                    check("samples", samples, e.len);
                    check("cumsum", cumsum, e.sum);
                    check("exptime", exptime, e.ts);
                    check("led_cnt", led[7:3], e.cnt % 32);
                end
            end
            trig_prev = (trigger === 1'b1);
            while (rd_q.size() > 0 && rd_q[0].tick <= tick_no) begin
                r = rd_q.pop_front();
                check("rd_data", rd_data, r.val);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        tick_no = 0;
        evt_cnt = 0;
        reset_reset_n = 1'b0;
        arm = 1'b0;
        ack = 1'b0;
        adc_valid = 1'b0;
        adc_data = '0;
        rd_ptr = '0;
        set_cfg(100, 3);
        repeat (3) tick();
        check("rst_trigger", trigger, 0);
        check("rst_samples", samples, 0);
        check("rst_cumsum", cumsum, 0);
        check("rst_exptime", exptime, 0);
        check("rst_led", led, 0);
        check("rst_rd_data", rd_data, 0);
        reset_reset_n = 1'b1;
        tick();
        check("idle_led", led, 0);
        do_arm();

        add_beat(1, 50); add_beat(1, 150); add_beat(1, 200); add_beat(1, 250); add_beat(1, 90);
        run_burst(0);

        add_beat(1, 150); add_beat(1, 160); add_beat(1, 90);
        run_burst(0);

        for (int k = 0; k < 600; k++) add_beat(1, (k == 5) ? 1234 : 1000);
        run_burst(0);

        add_beat(1, 101); add_beat(0, 5); add_beat(1, 300); add_beat(1, 102); add_beat(1, 100);
        run_burst(1);

        for (int n = 0; n < 12; n++) begin
            int len;
            set_cfg($urandom_range(50, 4000), $urandom_range(1, 6));
            len = $urandom_range(5, 40);
            for (int k = 0; k < len; k++)
                add_beat(($urandom % 5) != 0, $urandom_range(0, 2 * thr));
            run_burst(0);
        end

        set_cfg(100, 3);
        adc_valid = 1'b1;
        adc_data = 14'd150;
        tick();
        adc_data = 14'd160;
        tick();
        check("capture_led", led[2:0], 3'b010);
        adc_valid = 1'b0;
        arm = 1'b0;
        tick();
        check("disarm_trigger", trigger, 0);
        check("disarm_led", led, (evt_cnt % 32) << 3);
        tick();
        do_arm();
        repeat (4) tick();
        add_beat(1, 500); add_beat(1, 600); add_beat(1, 700);
        run_burst(0);

        adc_valid = 1'b1;
        adc_data = 14'd150;
        tick();
        adc_data = 14'd160;
        tick();
        #2;
        reset_reset_n = 1'b0;
        #1;
        check("arst_trigger", trigger, 0);
        check("arst_samples", samples, 0);
        check("arst_cumsum", cumsum, 0);
        check("arst_exptime", exptime, 0);
        check("arst_led", led, 0);
        check("arst_rd_data", rd_data, 0);
        adc_valid = 1'b0;
        evt_cnt = 0;
        tick();
        tick();
        reset_reset_n = 1'b1;
        do_arm();
        repeat (2) tick();
        add_beat(1, 400); add_beat(1, 401); add_beat(0, 9); add_beat(1, 402);
        run_burst(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
